// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave backed by a flop-array memory with independent read/write burst engines.
//   Clock/reset: aclk_i, asynchronous active-low aresetn_i.
//   AW/W/B: write address, write data (byte strobes) and write response channels.
//   AR/R:   read address and read data channels.
//   Out-of-range beats and illegal requests answer SLVERR; memory contents survive reset.
module axi_sram_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_WORDS      = 1024
) (
  input  logic                        aclk_i,
  input  logic                        aresetn_i,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic [2:0]                  aw_size_i,
  input  logic [1:0]                  aw_burst_i,
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                        w_last_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  output logic [AXI_ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]                  b_resp_o,
  output logic                        b_valid_o,
  input  logic                        b_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  input  logic [2:0]                  ar_size_i,
  input  logic [1:0]                  ar_burst_i,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  output logic [AXI_ID_WIDTH-1:0]     r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o,
  output logic                        r_valid_o,
  input  logic                        r_ready_i
);
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int IDW = AXI_ID_WIDTH;
  localparam int NB = DW / 8;
  localparam int IW = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] ONE = AW'(1);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  function automatic logic wrap_ok(input logic [7:0] len);
    return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
  endfunction
  function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
    return size > 3'd2 || burst == 2'b11 || (burst == 2'b10 && !wrap_ok(len));
  endfunction
  // Reserved bursts and malformed WRAPs fall back to INCR addressing.
  function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b11 || (burst == 2'b10 && !wrap_ok(len))) ? 2'b01 : burst;
  endfunction
  function automatic logic in_range(input logic [AW-1:0] a);
    return a[AW-1:2] < (AW-2)'(MEM_WORDS);
  endfunction
  // INCR re-aligns to the transfer size after the first beat; WRAP length is a power of two.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] n, l;
    n = ONE << size;
    l = (AW'(len) + ONE) * n;
    return burst == 2'b00 ? a :
           burst == 2'b10 ? (a & ~(l - ONE)) | ((a + n) & (l - ONE)) :
                            (a & ~(n - ONE)) + n;
  endfunction
  logic [DW-1:0] mem_q [MEM_WORDS];
  w_state_e w_state_q, w_state_d;
  logic [IDW-1:0] w_id_q, w_id_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [7:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0] w_size_q, w_size_d;
  logic [1:0] w_burst_q, w_burst_d;
  logic w_err_q, w_err_d, aw_ready_q;
  logic w_ok, w_last_beat, mem_we;
  r_state_e r_state_q, r_state_d;
  logic [IDW-1:0] r_id_q, r_id_d;
  logic [AW-1:0] r_addr_q, r_addr_d, r_next, rd_addr;
  logic [7:0] r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0] r_size_q, r_size_d;
  logic [1:0] r_burst_q, r_burst_d, r_resp_q, r_resp_d;
  logic [DW-1:0] r_data_q, r_data_d, rd_word;
  logic r_err_q, r_err_d, r_last_q, r_last_d, ar_ready_q, rd_ok;
  assign w_ok = in_range(w_addr_q);
  assign w_last_beat = w_cnt_q == w_len_q;
  assign mem_we = w_state_q == W_DATA && w_valid_i && w_ok;
  always_comb begin
    w_state_d = w_state_q;
    w_id_d = w_id_q;
    w_addr_d = w_addr_q;
    w_len_d = w_len_q;
    w_size_d = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d = w_cnt_q;
    w_err_d = w_err_q;
    case (w_state_q)
      W_IDLE: if (aw_valid_i && aw_ready_q) begin
        w_state_d = W_DATA;
        w_id_d = aw_id_i;
        w_addr_d = aw_addr_i;
        w_len_d = aw_len_i;
        w_size_d = aw_size_i;
        w_burst_d = eff_burst(aw_burst_i, aw_len_i);
        w_cnt_d = '0;
        w_err_d = bad_req(aw_size_i, aw_burst_i, aw_len_i);
      end
      W_DATA: if (w_valid_i) begin
        w_err_d = w_err_q | !w_ok | (w_last_i != w_last_beat);
        w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
        w_cnt_d = w_cnt_q + 8'd1;
        w_state_d = w_last_beat ? W_RESP : W_DATA;
      end
      W_RESP: w_state_d = b_ready_i ? W_IDLE : W_RESP;
      default: w_state_d = W_IDLE;
    endcase
  end
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      w_state_q <= W_IDLE;
      w_id_q <= '0;
      w_addr_q <= '0;
      w_len_q <= '0;
      w_size_q <= '0;
      w_burst_q <= '0;
      w_cnt_q <= '0;
      w_err_q <= 1'b0;
      aw_ready_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q <= w_id_d;
      w_addr_q <= w_addr_d;
      w_len_q <= w_len_d;
      w_size_q <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q <= w_cnt_d;
      w_err_q <= w_err_d;
      aw_ready_q <= w_state_d == W_IDLE;
    end
  end
  always_ff @(posedge aclk_i) begin
    if (mem_we)
      for (int i = 0; i < NB; i++)
        if (w_strb_i[i]) mem_q[w_addr_q[IW+1:2]][8*i +: 8] <= w_data_i[8*i +: 8];
  end
  // Read data is captured at the handshake edge, so a same-cycle write is seen one beat later.
  assign r_next = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
  assign rd_addr = r_state_q == R_IDLE ? ar_addr_i : r_next;
  assign rd_ok = in_range(rd_addr);
  assign rd_word = rd_ok ? mem_q[rd_addr[IW+1:2]] : '0;
  always_comb begin
    r_state_d = r_state_q;
    r_id_d = r_id_q;
    r_addr_d = r_addr_q;
    r_len_d = r_len_q;
    r_size_d = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d = r_cnt_q;
    r_err_d = r_err_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    r_last_d = r_last_q;
    case (r_state_q)
      R_IDLE: if (ar_valid_i && ar_ready_q) begin
        r_state_d = R_DATA;
        r_id_d = ar_id_i;
        r_addr_d = ar_addr_i;
        r_len_d = ar_len_i;
        r_size_d = ar_size_i;
        r_burst_d = eff_burst(ar_burst_i, ar_len_i);
        r_cnt_d = '0;
        r_err_d = bad_req(ar_size_i, ar_burst_i, ar_len_i);
        r_data_d = rd_word;
        r_resp_d = {r_err_d | !rd_ok, 1'b0};
        r_last_d = ar_len_i == 8'd0;
      end
      R_DATA: if (r_ready_i) begin
        if (r_last_q) r_state_d = R_IDLE;
        else begin
          r_addr_d = r_next;
          r_cnt_d = r_cnt_q + 8'd1;
          r_data_d = rd_word;
          r_resp_d = {r_err_q | !rd_ok, 1'b0};
          r_last_d = r_cnt_d == r_len_q;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_state_q <= R_IDLE;
      r_id_q <= '0;
      r_addr_q <= '0;
      r_len_q <= '0;
      r_size_q <= '0;
      r_burst_q <= '0;
      r_cnt_q <= '0;
      r_err_q <= 1'b0;
      r_data_q <= '0;
      r_resp_q <= '0;
      r_last_q <= 1'b0;
      ar_ready_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q <= r_id_d;
      r_addr_q <= r_addr_d;
      r_len_q <= r_len_d;
      r_size_q <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q <= r_cnt_d;
      r_err_q <= r_err_d;
      r_data_q <= r_data_d;
      r_resp_q <= r_resp_d;
      r_last_q <= r_last_d;
      ar_ready_q <= r_state_d == R_IDLE;
    end
  end
  assign aw_ready_o = aw_ready_q;
  assign w_ready_o = w_state_q == W_DATA;
  assign b_valid_o = w_state_q == W_RESP;
  assign b_id_o = w_id_q;
  assign b_resp_o = {w_err_q, 1'b0};
  assign ar_ready_o = ar_ready_q;
  assign r_valid_o = r_state_q == R_DATA;
  assign r_id_o = r_id_q;
  assign r_data_o = r_data_q;
  assign r_resp_o = r_resp_q;
  assign r_last_o = r_last_q;
endmodule
